// File: rtl/adc_scheduler_if.sv
// Bus between adc_scheduler, the ADC block and the paddle/game logic.
// master = scheduler side, slave = ADC/game-logic side.
interface adc_scheduler_if;
   localparam int unsigned DATA_W = 7;

   logic              enable;
   logic [DATA_W-1:0] adc_out;
   logic              adc_sampled;
   logic              adc_start;
   logic              mux_sel;
   logic [DATA_W-1:0] paddle0;
   logic [DATA_W-1:0] paddle1;
   logic [1:0]        valid;
   logic [1:0]        fault;
   logic              updated;

   modport master (
      input  enable, adc_out, adc_sampled,
      output adc_start, mux_sel, paddle0, paddle1, valid, fault, updated
   );

   modport slave (
      output enable, adc_out, adc_sampled,
      input  adc_start, mux_sel, paddle0, paddle1, valid, fault, updated
   );
endinterface

// File: rtl/adc_scheduler.sv
// Time-shares one ADC between two paddle pots: mux select, settle, restart, capture.
// Optional macro ADC_SCHED_AVG_EN: store the 2-sample running average instead of the raw sample.
module adc_scheduler #(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input logic                clk,
   input logic                rst_n,
   adc_scheduler_if.master    bus
);
   localparam int unsigned CNT_W  = 10;
   localparam int unsigned DATA_W = 7;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, SELECT, START, CONVERT, STORE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              ch;
   logic              adc_start;
   logic [DATA_W-1:0] sample;
   logic              sample_ok;
   logic [DATA_W-1:0] paddle0;
   logic [DATA_W-1:0] paddle1;
   logic [1:0]        valid;
   logic [1:0]        fault;
   logic              updated;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] store_val;

   // Saturating counter so it can never wrap inside a state
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

`ifdef ADC_SCHED_AVG_EN
   logic [DATA_W-1:0] cur_paddle;
   logic [DATA_W:0]   avg_sum;

   assign cur_paddle = ch ? paddle1 : paddle0;
   assign avg_sum    = {1'b0, cur_paddle} + {1'b0, sample};
   // First sample after reset has nothing to average with
   assign store_val  = valid[ch] ? avg_sum[DATA_W:1] : sample;
`else
   assign store_val  = sample;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         ch        <= 1'b0;
         adc_start <= 1'b0;
         sample    <= '0;
         sample_ok <= 1'b0;
         paddle0   <= '0;
         paddle1   <= '0;
         valid     <= 2'b00;
         fault     <= 2'b00;
         updated   <= 1'b0;
      end else begin
         adc_start <= 1'b0;
         updated   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.enable) begin
                  state <= SELECT;
                  cnt   <= '0;
               end
            end
            SELECT: begin
               if (cnt == SETTLE_LAST) begin
                  state     <= START;
                  adc_start <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            START: begin
               state <= CONVERT;
               cnt   <= '0;
            end
            CONVERT: begin
               if (bus.adc_sampled) begin
                  sample    <= bus.adc_out;
                  sample_ok <= 1'b1;
                  state     <= STORE;
               end else if (cnt == TIMEOUT_CNT) begin
                  fault[ch] <= 1'b1;
                  sample_ok <= 1'b0;
                  state     <= STORE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            STORE: begin
               if (sample_ok) begin
                  if (ch) paddle1 <= store_val;
                  else    paddle0 <= store_val;
                  valid[ch] <= 1'b1;
                  fault[ch] <= 1'b0;
                  updated   <= 1'b1;
               end
               // Mux moves with Updated so the next channel gets its full settle time
               ch    <= ~ch;
               cnt   <= '0;
               state <= bus.enable ? SELECT : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.adc_start = adc_start;
   assign bus.mux_sel   = ch;
   assign bus.paddle0   = paddle0;
   assign bus.paddle1   = paddle1;
   assign bus.valid     = valid;
   assign bus.fault     = fault;
   assign bus.updated   = updated;
endmodule

// File: tb/tb_adc_scheduler.sv
// Randomized self-checking bench for adc_scheduler with a per-conversion reference model.
module tb_adc_scheduler;
   localparam int unsigned SETTLE  = 16;
   localparam int unsigned TIMEOUT = 1023;
`ifdef ADC_SCHED_AVG_EN
   localparam logic [6:0] SECOND_CH0 = 7'h30;
`else
   localparam logic [6:0] SECOND_CH0 = 7'h20;
`endif

   logic clk;
   logic rst_n;
   int unsigned n_checks;
   int unsigned n_errors;
   int unsigned upd_cnt;

   logic [6:0] m_paddle [2];
   logic [1:0] m_valid;
   logic [1:0] m_fault;
   logic       m_ch;

   adc_scheduler_if bus ();

   adc_scheduler #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (bus.updated === 1'b1) upd_cnt <= upd_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_paddle0"}, 32'(bus.paddle0), 32'(m_paddle[0]));
      check_eq({tag, "_paddle1"}, 32'(bus.paddle1), 32'(m_paddle[1]));
      check_eq({tag, "_valid"},   32'(bus.valid),   32'(m_valid));
      check_eq({tag, "_fault"},   32'(bus.fault),   32'(m_fault));
      check_eq({tag, "_mux"},     32'(bus.mux_sel), 32'(m_ch));
   endtask

   task automatic model_reset();
      m_paddle[0] = '0;
      m_paddle[1] = '0;
      m_valid     = 2'b00;
      m_fault     = 2'b00;
      m_ch        = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n           = 1'b0;
      bus.enable      = 1'b0;
      bus.adc_sampled = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One channel conversion as seen from the ADC side. Returns one clock into the next SELECT/IDLE.
   task automatic conv(input bit respond, input logic [6:0] val, input int unsigned dly,
                       input bit stale, input bit drop_en, output int unsigned lat);
      int unsigned n;
      int unsigned k;
      bit          saw_upd;
      logic        c;
      n = 0;
      c = m_ch;
      while (bus.adc_start !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
         bus.adc_sampled = 1'b0;
         if (stale && n == 3 && bus.adc_start !== 1'b1) begin
            bus.adc_sampled = 1'b1;
            bus.adc_out     = 7'($urandom);
         end
      end
      lat = n;
      if (bus.adc_start !== 1'b1) begin
         check_eq("start_seen", 32'(bus.adc_start), 32'd1);
         return;
      end
      check_eq("start_mux", 32'(bus.mux_sel), 32'(c));
      @(negedge clk);
      check_eq("start_width", 32'(bus.adc_start), 32'd0);
      if (drop_en) bus.enable = 1'b0;
      if (respond) begin
         for (int i = 1; i < int'(dly); i++) @(negedge clk);
         bus.adc_sampled = 1'b1;
         bus.adc_out     = val;
         @(negedge clk);
         bus.adc_sampled = 1'b0;
         bus.adc_out     = 7'($urandom);
         check_eq("upd_early", 32'(bus.updated), 32'd0);
         @(negedge clk);
`ifdef ADC_SCHED_AVG_EN
         if (m_valid[c]) m_paddle[c] = 7'((int'(m_paddle[c]) + int'(val)) / 2);
         else            m_paddle[c] = val;
`else
         m_paddle[c] = val;
`endif
         m_valid[c] = 1'b1;
         m_fault[c] = 1'b0;
         m_ch       = ~c;
         check_eq("upd_pulse", 32'(bus.updated), 32'd1);
         check_state("store");
      end else begin
         k       = 0;
         saw_upd = 1'b0;
         while (bus.fault[c] !== 1'b1 && k < 1200) begin
            @(negedge clk);
            k++;
            if (bus.updated === 1'b1) saw_upd = 1'b1;
         end
         // START cycle + TIMEOUT counted clocks + one clock to show Fault
         check_eq("timeout_lat", 32'(k + 1), 32'(TIMEOUT + 2));
         check_eq("timeout_noupd", 32'(saw_upd), 32'd0);
         m_fault[c] = 1'b1;
         @(negedge clk);
         m_ch = ~c;
         check_eq("timeout_upd", 32'(bus.updated), 32'd0);
         check_state("timeout");
      end
      @(negedge clk);
      check_eq("upd_width", 32'(bus.updated), 32'd0);
   endtask

   initial begin
      int unsigned lat;
      int unsigned starts;
      int unsigned u0;
      n_checks        = 0;
      n_errors        = 0;
      upd_cnt         = 0;
      rst_n           = 1'b0;
      bus.enable      = 1'b0;
      bus.adc_sampled = 1'b0;
      bus.adc_out     = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Idle after reset
      check_state("rst");
      check_eq("rst_start", 32'(bus.adc_start), 32'd0);
      check_eq("rst_upd",   32'(bus.updated),   32'd0);
      starts = 0;
      repeat (500) begin
         @(negedge clk);
         if (bus.adc_start === 1'b1) starts++;
      end
      check_eq("idle_starts", starts, 32'd0);

      // First scan: fixed values, latency from Enable
      u0 = upd_cnt;
      bus.enable = 1'b1;
      conv(1'b1, 7'h2A, 5, 1'b0, 1'b0, lat);
      check_eq("enable_lat", lat, 32'(SETTLE + 1));
      conv(1'b1, 7'h55, 9, 1'b1, 1'b0, lat);
      check_eq("settle_lat", lat, 32'(SETTLE - 1));
      check_eq("scan_paddle0", 32'(bus.paddle0), 32'h2A);
      check_eq("scan_paddle1", 32'(bus.paddle1), 32'h55);
      check_eq("scan_valid",   32'(bus.valid),   32'h3);
      check_eq("scan_updates", upd_cnt - u0,     32'd2);

      // Random scan with stale strobes in SELECT
      for (int i = 0; i < 16; i++) begin
         conv(1'b1, 7'($urandom), $urandom_range(1, 40), 1'($urandom_range(0, 1)), 1'b0, lat);
         check_eq("rand_settle_lat", lat, 32'(SETTLE - 1));
      end

      // Enable dropped during a ch1 conversion
      if (m_ch == 1'b0) conv(1'b1, 7'($urandom), 3, 1'b0, 1'b0, lat);
      conv(1'b1, 7'($urandom), 7, 1'b0, 1'b1, lat);
      starts = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.adc_start === 1'b1) starts++;
      end
      check_eq("drop_starts", starts, 32'd0);
      check_state("drop_idle");

      // Averaging (or not) on ch0
      do_reset();
      bus.enable = 1'b1;
      conv(1'b1, 7'h40, 4, 1'b0, 1'b0, lat);
      check_eq("rst_enable_lat", lat, 32'(SETTLE + 1));
      check_eq("avg_first", 32'(bus.paddle0), 32'h40);
      conv(1'b1, 7'($urandom), 4, 1'b0, 1'b0, lat);
      conv(1'b1, 7'h20, 4, 1'b0, 1'b0, lat);
      check_eq("avg_second", 32'(bus.paddle0), 32'(SECOND_CH0));

      // Timeout on ch0 after reset
      do_reset();
      bus.enable = 1'b1;
      conv(1'b0, 7'h00, 1, 1'b0, 1'b0, lat);
      check_eq("to_fault",   32'(bus.fault),   32'h1);
      check_eq("to_paddle0", 32'(bus.paddle0), 32'h0);
      check_eq("to_valid",   32'(bus.valid),   32'h0);
      conv(1'b1, 7'($urandom), 6, 1'b0, 1'b0, lat);
      check_eq("to_next_ch_valid", 32'(bus.valid), 32'h2);
      conv(1'b1, 7'($urandom), 6, 1'b0, 1'b0, lat);
      check_eq("to_fault_clear", 32'(bus.fault), 32'h0);

      // Asynchronous reset while ADCStart is high
      starts = 0;
      while (bus.adc_start !== 1'b1 && starts < 400) begin
         @(negedge clk);
         starts++;
      end
      check_eq("pre_rst_start", 32'(bus.adc_start), 32'd1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("async_start", 32'(bus.adc_start), 32'd0);
      check_state("async");
      bus.enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_state("async_after");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
